// File: rtl/blink_monitor.sv
// ---------------------------------------------------------------------------
// blink_monitor
//   Receive-side companion to the blinking-light FSM. Measures the length
//   (in clock cycles) of every ON phase and OFF phase of a single-bit light
//   signal. Both lengths are published once per complete ON+OFF period. A
//   light that shows no edge for longer than TIMEOUT cycles is flagged as
//   stuck.
//
// Parameters
//   CNT_W    width of the phase counter and of the length outputs
//   TIMEOUT  cycles without an edge before a fault (2 .. 2**CNT_W-1)
//
// Ports
//   clk_i      in   clock
//   rst_ni     in   asynchronous reset, active-low
//   enable_i   in   1 = monitor runs, 0 = forced back to IDLE
//   light_i    in   monitored light level
//   on_len_o   out  length of the last complete ON phase
//   off_len_o  out  length of the last complete OFF phase
//   valid_o    out  one-cycle pulse, lengths just updated
//   fault_o    out  light stuck, held until the next rise or a disable
//   stuck_o    out  level the light was stuck at (meaningful while fault_o)
//
// Build option
//   BLINK_MON_SYNC_EN  when defined, light_i passes through a 2-FF
//                      synchronizer first (valid_o latency 4 edges instead
//                      of 2; measured lengths are unaffected).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module blink_monitor #(
  parameter int CNT_W   = 26,
  parameter int TIMEOUT = 2**CNT_W - 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             light_i,
  output logic [CNT_W-1:0] on_len_o,
  output logic [CNT_W-1:0] off_len_o,
  output logic             valid_o,
  output logic             fault_o,
  output logic             stuck_o
);

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_MEAS_ON,
    S_MEAS_OFF,
    S_FAULT
  } state_t;

  // Phase counter increment, pinned at TIMEOUT so a stuck light cannot wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TO) ? TO : v + ONE;
  endfunction

  logic w_light_in;

  // --- optional synchronizer stage (asynchronous light_i) ---
`ifdef BLINK_MON_SYNC_EN
  logic r_sync_p0;
  logic r_sync_p1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= light_i;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_light_in = r_sync_p1;
`else
  assign w_light_in = light_i;
`endif

  // --- sample stage: current and previous light level ---
  logic r_light_s;
  logic r_light_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_light_s <= 1'b0;
      r_light_d <= 1'b0;
    end else begin
      r_light_s <= w_light_in;
      r_light_d <= r_light_s;
    end
  end

  logic w_rise;
  logic w_fall;

  assign w_rise = r_light_s & ~r_light_d;
  assign w_fall = ~r_light_s & r_light_d;

  // --- measurement FSM with registered outputs ---
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_on_lat;
  logic [CNT_W-1:0] r_on_len;
  logic [CNT_W-1:0] r_off_len;
  logic             r_valid;
  logic             r_fault;
  logic             r_stuck;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_on_lat  <= '0;
      r_on_len  <= '0;
      r_off_len <= '0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
      r_stuck   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!enable_i) begin
        // Disable wins over any edge or timeout in the same cycle.
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_fault <= 1'b0;
        r_stuck <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_ARM;
            r_cnt   <= '0;
          end
          // A light already high when enabled is skipped: only a fresh
          // rise starts the first measured ON phase.
          S_ARM: begin
            if (w_rise) begin
              r_state <= S_MEAS_ON;
              r_cnt   <= ONE;
            end else begin
              r_cnt <= '0;
            end
          end
          S_MEAS_ON: begin
            if (w_fall) begin
              r_on_lat <= r_cnt;
              r_cnt    <= ONE;
              r_state  <= S_MEAS_OFF;
            end else if (r_cnt == TO) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
              r_stuck <= r_light_s;
            end else begin
              r_cnt <= sat_inc(r_cnt);
            end
          end
          S_MEAS_OFF: begin
            if (w_rise) begin
              r_on_len  <= r_on_lat;
              r_off_len <= r_cnt;
              r_valid   <= 1'b1;
              r_cnt     <= ONE;
              r_state   <= S_MEAS_ON;
            end else if (r_cnt == TO) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
              r_stuck <= r_light_s;
            end else begin
              r_cnt <= sat_inc(r_cnt);
            end
          end
          // Only a rise leaves FAULT; it restarts an ON phase but does not
          // complete a period, so no valid_o here.
          S_FAULT: begin
            if (w_rise) begin
              r_state <= S_MEAS_ON;
              r_cnt   <= ONE;
              r_fault <= 1'b0;
              r_stuck <= 1'b0;
            end else begin
              r_cnt <= sat_inc(r_cnt);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign on_len_o  = r_on_len;
  assign off_len_o = r_off_len;
  assign valid_o   = r_valid;
  assign fault_o   = r_fault;
  assign stuck_o   = r_stuck;

endmodule

// File: tb/tb_blink_monitor.sv
// ---------------------------------------------------------------------------
// tb_blink_monitor
//   Directed bench for blink_monitor (CNT_W=8, TIMEOUT=20). A behavioural
//   model derives the expected outputs from run lengths of the sampled light
//   waveform; a compare process checks it against the DUT every cycle, and
//   hand-computed literal expectations pin lengths, latency and fault timing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_blink_monitor;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 20;
`ifdef BLINK_MON_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             light = 1'b0;
  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] off_len;
  logic             valid;
  logic             fault;
  logic             stuck;

  int n_vec    = 0;
  int n_err    = 0;
  int n_pulses = 0;
  int gap      = 0;
  int last_v   = -1;
  int cyc_no   = 0;

  blink_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .enable_i (en),
    .light_i  (light),
    .on_len_o (on_len),
    .off_len_o(off_len),
    .valid_o  (valid),
    .fault_o  (fault),
    .stuck_o  (stuck)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // The sampled light (light_s) is light_i delayed by 1+SYNC edges. A phase
  // length is simply the run length of equal samples. Tracking begins at the
  // first rise after enable; a rise while tracking closes a period; a run
  // that grows past TIMEOUT while tracking is a stuck light.
  typedef enum {M_OFF, M_ARMED, M_TRACK, M_STUCK} mode_t;

  logic [2:0]       m_pipe = '0;
  logic [3:0]       m_vec;
  logic             m_ld   = 1'b0;
  int               m_run_s = 0;
  int               m_run_d = 0;
  int               hi_len = 0;
  mode_t            mode   = M_OFF;
  logic [CNT_W-1:0] m_on   = '0;
  logic [CNT_W-1:0] m_off  = '0;
  logic             m_valid = 1'b0;
  logic             m_fault = 1'b0;
  logic             m_stuck = 1'b0;

  assign m_vec = {m_pipe, light};
  wire m_s    = m_vec[SYNC+1];
  wire m_nxt  = m_vec[SYNC];
  wire m_rise = m_s & ~m_ld;
  wire m_fall = ~m_s & m_ld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pipe  <= '0;
      m_ld    <= 1'b0;
      m_run_s <= 0;
      m_run_d <= 0;
      hi_len  <= 0;
      mode    <= M_OFF;
      m_on    <= '0;
      m_off   <= '0;
      m_valid <= 1'b0;
      m_fault <= 1'b0;
      m_stuck <= 1'b0;
    end else begin
      m_pipe  <= {m_pipe[1:0], light};
      m_ld    <= m_s;
      m_run_d <= m_run_s;
      m_run_s <= (m_nxt == m_s) ? ((m_run_s < 1000) ? m_run_s + 1 : m_run_s) : 1;
      m_valid <= 1'b0;
      if (!en) begin
        mode    <= M_OFF;
        m_fault <= 1'b0;
        m_stuck <= 1'b0;
      end else begin
        case (mode)
          M_OFF:   mode <= M_ARMED;
          M_ARMED: if (m_rise) mode <= M_TRACK;
          M_TRACK: begin
            if (m_fall) begin
              hi_len <= m_run_d;
            end else if (m_rise) begin
              m_valid <= 1'b1;
              m_on    <= CNT_W'(hi_len);
              m_off   <= CNT_W'(m_run_d);
            end else if (m_run_d >= TIMEOUT) begin
              mode    <= M_STUCK;
              m_fault <= 1'b1;
              m_stuck <= m_s;
            end
          end
          M_STUCK: begin
            if (m_rise) begin
              mode    <= M_TRACK;
              m_fault <= 1'b0;
              m_stuck <= 1'b0;
            end
          end
          default: mode <= M_OFF;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc_no++;
      n_vec++;
      if ({valid, fault, stuck, on_len, off_len} !== {m_valid, m_fault, m_stuck, m_on, m_off}) begin
        n_err++;
        $display("FAIL cycle%0d outputs: got v=%b f=%b s=%b on=%0d off=%0d, want v=%b f=%b s=%b on=%0d off=%0d",
                 cyc_no, valid, fault, stuck, on_len, off_len, m_valid, m_fault, m_stuck, m_on, m_off);
      end
      if (valid === 1'b1) begin
        if (last_v >= 0) gap = cyc_no - last_v;
        last_v = cyc_no;
        n_pulses++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Move past the next negedge so the pulse counter has seen the last edge.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int p;
    int k;

    cyc(3);
    check("reset_outputs", int'({valid, fault, stuck, on_len, off_len}), 0);
    rst_n = 1'b1;
    cyc(1);

    // Test 1: 3 high / 2 low
    en = 1'b1;
    cyc(2);
    p = n_pulses;
    for (int i = 0; i < 6; i++) begin
      light = 1'b1; cyc(3);
      light = 1'b0; cyc(2);
    end
    settle();
    check("t1_pulses", n_pulses - p, 5);
    check("t1_on_len", int'(on_len), 3);
    check("t1_off_len", int'(off_len), 2);
    check("t1_gap", gap, 5);
    check("t1_model_on", int'(m_on), 3);
    check("t1_model_off", int'(m_off), 2);

    // valid_o latency from a light_i rise
    cyc(1);
    light = 1'b1;
    k = 0;
    while (valid !== 1'b1 && k < 12) begin
      cyc(1);
      k++;
    end
    check("t1_latency", k, 2 + SYNC);
    cyc(1);
    light = 1'b0; cyc(2);

    // Test 2: 1 high / 1 low
    for (int i = 0; i < 8; i++) begin
      light = 1'b1; cyc(1);
      light = 1'b0; cyc(1);
    end
    check("t2_on_len", int'(on_len), 1);
    check("t2_off_len", int'(off_len), 1);
    check("t2_gap", gap, 2);

    // Test 3: held low -> fault after the 22nd edge since the low drive
    k = 1;
    while (fault !== 1'b1 && k < 60) begin
      cyc(1);
      k++;
    end
    check("t3_fault_edge", k, 22 + SYNC);
    check("t3_stuck_level", int'(stuck), 0);
    cyc(3);
    check("t3_fault_sticky", int'(fault), 1);
    p = n_pulses;
    light = 1'b1; cyc(2 + SYNC);
    check("t3_fault_cleared", int'(fault), 0);
    cyc(2);
    light = 1'b0; cyc(3);
    settle();
    check("t3_no_valid", n_pulses - p, 0);
    light = 1'b1; cyc(2 + SYNC);
    settle();
    check("t3_next_valid", n_pulses - p, 1);
    check("t3_on_len", int'(on_len), 4 + SYNC);
    check("t3_off_len", int'(off_len), 3);

    // Test 4: disable mid ON phase, re-enable with light high
    cyc(1);
    en = 1'b0; cyc(1);
    check("t4_fault_off", int'(fault), 0);
    check("t4_valid_off", int'(valid), 0);
    cyc(4);
    check("t4_on_hold", int'(on_len), 4 + SYNC);
    check("t4_off_hold", int'(off_len), 3);
    en = 1'b1;
    p = n_pulses;
    cyc(6);
    light = 1'b0; cyc(2);
    light = 1'b1; cyc(2);
    settle();
    check("t4_no_count_high", n_pulses - p, 0);
    light = 1'b0; cyc(2);
    light = 1'b1; cyc(2 + SYNC);
    settle();
    check("t4_fresh_valid", n_pulses - p, 1);
    check("t4_on_len", int'(on_len), 2);
    check("t4_off_len", int'(off_len), 2);

    // Test 5: asynchronous reset during the OFF phase
    cyc(1);
    light = 1'b0; cyc(3 + SYNC);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", int'({valid, fault, stuck, on_len, off_len}), 0);
    @(posedge clk);
    #1;
    check("t5_held_clear", int'({valid, fault, stuck, on_len, off_len}), 0);
    rst_n = 1'b1;
    p = n_pulses;
    cyc(2);
    for (int i = 0; i < 3; i++) begin
      light = 1'b1; cyc(3);
      light = 1'b0; cyc(2);
    end
    settle();
    check("t5_resume_pulses", n_pulses - p, 2);
    check("t5_on_len", int'(on_len), 3);
    check("t5_off_len", int'(off_len), 2);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
